// File: rtl/mult_ex_sequencer.sv
// Purpose: iterative shift-add MULT/MULTU unit sequenced from the EX stage, one bit per cycle.
// Latency: WIDTH+1 cycles from acceptance to the done pulse; hi/lo update on the edge after done.
// Backpressure: stall holds IF/ID/EX from acceptance through the last RUN cycle; flush or reset abandons.
module mult_ex_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   a_mag, b_mag, addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        // Magnitude of the most negative value wraps to itself, which is correct as unsigned.
        a_mag  = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
        b_mag  = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
        addend = mplier_q[0] ? mcand_q : '0;
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        prod   = neg_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        stall    = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    stall    = 1'b1;
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    neg_d    = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    stall    = 1'b1;
                    acc_d    = {sum, acc_q[WIDTH-1:1]};
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Any start seen here is the same instruction still sitting in EX.
                state_d = IDLE;
                if (!flush) begin
                    done         = 1'b1;
                    {hi_d, lo_d} = prod;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!reset) begin
            stall = 1'b0;
            done  = 1'b0;
        end

        busy_d = (state_d == RUN) || (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_ex_sequencer.sv
// Bench for mult_ex_sequencer: cycle-age reference model plus directed literal checks.
// Latency: checks every cycle after the first reset edge.
// Backpressure: start is held high while stalled, as the EX stage would.
module tb_mult_ex_sequencer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         stall, busy, done;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int stall_cnt = 0;
    int done_cyc = -1;

    // Reference model: age of the in-flight op (-1 idle, 1..W computing, W+1 finishing).
    int             m_age = -1;
    logic [2*W-1:0] m_prod = '0;
    logic [W-1:0]   m_hi = '0;
    logic [W-1:0]   m_lo = '0;
    bit             m_valid = 1'b0;

    always #5 clk = ~clk;

    mult_ex_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .flush     (flush),
        .op_a      (op_a),
        .op_b      (op_b),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            m_age   = -1;
            m_hi    = '0;
            m_lo    = '0;
            m_valid = 1'b1;
        end else if (m_age == -1) begin
            if (start && !flush) begin
                m_age = 1;
                if (is_signed)
                    m_prod = longint'($signed(op_a)) * longint'($signed(op_b));
                else
                    m_prod = {32'b0, op_a} * {32'b0, op_b};
            end
        end else if (m_age <= W) begin
            m_age = flush ? -1 : m_age + 1;
        end else begin
            if (!flush) {m_hi, m_lo} = m_prod;
            m_age = -1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_stall", stall,
                reset && !flush && ((m_age == -1 && start) || (m_age >= 1 && m_age <= W)));
            chk("model_done", done, reset && !flush && (m_age == W + 1));
            chk("model_busy", busy, m_age >= 1);
            chk("model_hi", hi, m_hi);
            chk("model_lo", lo, m_lo);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (stall === 1'b1) stall_cnt++;
    end

    // Called #1 after an edge; returns #1 into the cycle after done with start dropped.
    task automatic run_op(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input string nm);
        int t0, n0, s0;
        start = 1'b1; is_signed = sgn; op_a = a; op_b = b;
        t0 = cyc; n0 = done_cnt; s0 = stall_cnt;
        for (int i = 0; i < 100 && done_cnt == n0; i++) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({nm, "_done_seen"}, done_cnt - n0, 1);
        chk({nm, "_latency"}, done_cyc - t0, 33);
        chk({nm, "_stall_cycles"}, stall_cnt - s0, 33);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        int n0, d_first;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_stall", stall, 0);
        reset = 1'b1;
        tick();

        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        run_op(1, -32'sd3, 32'sd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5");
        run_op(1, -32'sd7, -32'sd6, 32'h0000_0000, 32'h0000_002A, "mult_m7xm6");
        run_op(1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minmin");
        run_op(0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "multu_minmin");
        run_op(0, 32'h0, 32'h5, 32'h0, 32'h0, "zero_a");
        run_op(1, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, "zero_signed");

        // Back-to-back: second start in the cycle right after done.
        run_op(0, 32'hFFFF_0000, 32'h2, 32'h1, 32'hFFFE_0000, "b2b_first");
        d_first = done_cyc;
        run_op(0, 32'h0001_0000, 32'h0003_0000, 32'h3, 32'h0, "b2b_second");
        chk("b2b_done_spacing", done_cyc - d_first, 34);

        // Preload hi/lo = 1/2, then flush in RUN cycle 10.
        run_op(0, 32'h2, 32'h8000_0001, 32'h1, 32'h2, "preload");
        start = 1'b1; is_signed = 1'b0; op_a = 32'h4; op_b = 32'h4;
        n0 = done_cnt;
        repeat (10) tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_run_stall", stall, 0);
        tick();
        flush = 1'b0; start = 1'b0;
        chk("flush_run_busy", busy, 0);
        repeat (40) tick();
        chk("flush_run_no_done", done_cnt - n0, 0);
        chk("flush_run_hi", hi, 32'h1);
        chk("flush_run_lo", lo, 32'h2);

        // Flush during the done cycle suppresses the commit.
        start = 1'b1; op_a = 32'h3; op_b = 32'h3;
        n0 = done_cnt;
        repeat (33) tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_done_pulse", done, 0);
        tick();
        flush = 1'b0; start = 1'b0;
        chk("flush_done_busy", busy, 0);
        chk("flush_done_count", done_cnt - n0, 0);
        chk("flush_done_hi", hi, 32'h1);
        chk("flush_done_lo", lo, 32'h2);

        // Start together with flush in IDLE is not accepted.
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("idle_flush_stall", stall, 0);
        tick();
        start = 1'b0; flush = 1'b0;
        chk("idle_flush_busy", busy, 0);

        // Reset in RUN cycle 5 with start still high.
        start = 1'b1; op_a = 32'h5; op_b = 32'h5;
        n0 = done_cnt;
        repeat (5) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_run_stall", stall, 0);
        tick();
        reset = 1'b1; start = 1'b0;
        chk("reset_run_busy", busy, 0);
        chk("reset_run_hi", hi, 0);
        chk("reset_run_lo", lo, 0);
        repeat (40) tick();
        chk("reset_run_no_done", done_cnt - n0, 0);
        run_op(0, 32'h6, 32'h7, 32'h0, 32'h2A, "after_reset");

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
